// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo
//    Receives 11-bit PS/2 keyboard frames (start 0, 8 data bits LSB first,
//    odd parity, stop 1) and queues each valid byte in a small FIFO for a
//    consumer that pops with an active-low request.
//
// Parameters
//    DEPTH      FIFO entries, power of two, >= 2
//    TIMEOUT    clk cycles without a PS/2 falling edge before a partial frame
//               is abandoned
//
// Ports
//    clk         in   system clock, the only clock
//    clrn        in   asynchronous active-low reset
//    ps2_clk     in   raw PS/2 clock, asynchronous to clk
//    ps2_data    in   raw PS/2 data, asynchronous to clk
//    nextdata_n  in   active-low pop request
//    data        out  byte at the FIFO head, 8'h00 when empty
//    ready       out  FIFO not empty
//    overflow    out  sticky: a received byte was dropped, cleared by a pop
//    frame_err   out  one-cycle pulse when a frame fails its stop/parity check
//    level       out  current FIFO occupancy
module ps2_rx_fifo #(
   parameter int DEPTH   = 8,
   parameter int TIMEOUT = 50000
) (
   input  logic                     clk,
   input  logic                     clrn,
   input  logic                     ps2_clk,
   input  logic                     ps2_data,
   input  logic                     nextdata_n,
   output logic [7:0]               data,
   output logic                     ready,
   output logic                     overflow,
   output logic                     frame_err,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [LW-1:0] FULL_LEVEL   = LW'(DEPTH);
   localparam logic [TW-1:0] TIMER_LIMIT  = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, STOP} state_t;

   state_t          state;
   state_t          state_next;

   logic [2:0]      clk_sync;
   logic [1:0]      data_sync;
   logic            fall;
   logic            bit_in;

   logic [3:0]      bit_cnt;
   logic [8:0]      shift_reg;
   logic [TW-1:0]   timer;
   logic            timed_out;

   logic            wr_req;
   logic            err_det;
   logic            wr_en;
   logic            pop;
   logic            full;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;

   // Synchronisers. The clock path carries one extra stage so that the edge
   // detector compares two settled samples; the data path is two stages so
   // its output lines up with the newer of those two clock samples.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         clk_sync  <= 3'b111;
         data_sync <= 2'b11;
      end else begin
         clk_sync  <= {clk_sync[1:0], ps2_clk};
         data_sync <= {data_sync[0], ps2_data};
      end
   end

   assign fall   = clk_sync[2] & ~clk_sync[1];
   assign bit_in = data_sync[1];

   // A stalled frame is abandoned once TIMEOUT cycles have passed without
   // any falling edge while a frame is in progress.
   assign timed_out = (state != IDLE) && !fall && (timer == TIMER_LIMIT);

   // State register.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. The byte is only offered to the FIFO once the stop
   // bit has been seen and the nine data+parity bits hold an odd count of
   // ones, so a partial byte can never be written.
   always_comb begin
      state_next = state;
      wr_req     = 1'b0;
      err_det    = 1'b0;
      case (state)
         IDLE: begin
            if (fall && !bit_in) begin
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            if (timed_out) begin
               state_next = IDLE;
            end else if (fall && (bit_cnt == 4'd8)) begin
               state_next = STOP;
            end
         end
         STOP: begin
            if (timed_out) begin
               state_next = IDLE;
            end else if (fall) begin
               state_next = IDLE;
               if (bit_in && (^shift_reg)) begin
                  wr_req = 1'b1;
               end else begin
                  err_det = 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Frame datapath: bits arrive LSB first and are shifted in from the top,
   // so after nine bits the data byte sits in [7:0] and parity in [8].
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         bit_cnt   <= 4'd0;
         shift_reg <= 9'd0;
         timer     <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= err_det;
         if (state == IDLE || fall || timed_out) begin
            timer <= '0;
         end else begin
            timer <= timer + 1'b1;
         end
         if (state == IDLE && fall && !bit_in) begin
            bit_cnt   <= 4'd0;
            shift_reg <= 9'd0;
         end else if (state == SHIFT && fall) begin
            shift_reg <= {bit_in, shift_reg[8:1]};
            bit_cnt   <= bit_cnt + 4'd1;
         end
      end
   end

   // FIFO control. A write into a full FIFO is still accepted when a pop
   // happens in the same cycle, since that pop frees the slot.
   assign full  = (level == FULL_LEVEL);
   assign ready = (level != '0);
   assign pop   = !nextdata_n && ready;
   assign wr_en = wr_req && (!full || pop);
   assign data  = ready ? mem[rd_ptr] : 8'h00;

   // Storage array; contents need no reset because level gates visibility.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= shift_reg[7:0];
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({wr_en, pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
         if (pop) begin
            overflow <= 1'b0;
         end else if (wr_req && full) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter TIMEOUT, default 50000, clk cycles without a PS/2 falling edge before an in-progress frame is abandoned.
REQ-003 SHALL have port clk  input  1  system clock, the only clock.
REQ-004 SHALL have port clrn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ps2_clk  input  1  raw PS/2 clock from the keyboard, asynchronous to clk.
REQ-006 SHALL have port ps2_data  input  1  raw PS/2 data, asynchronous to clk.
REQ-007 SHALL have port nextdata_n  input  1  active-low pop request from the consumer.
REQ-008 SHALL have port data  output  8  scancode at the FIFO head.
REQ-009 SHALL have port ready  output  1  FIFO not empty.
REQ-010 SHALL have port overflow  output  1  sticky flag: a received byte was dropped.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse: a frame was rejected.
REQ-012 SHALL have port level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-013 SHALL pass ps2_clk through 3 flops and ps2_data through 2 flops; a falling edge is the previous sync sample 1 and the current sync sample 0; every bit is sampled only on a falling edge.
REQ-014 SHALL accept an 11-bit frame: start bit 0, 8 data bits LSB first, odd parity, stop bit 1.
REQ-015 SHALL use an FSM with states IDLE, SHIFT and STOP.
REQ-016 IDLE: on a falling edge with data 0, go to SHIFT with bit count 0; on a falling edge with data 1, stay in IDLE with no flag.
REQ-017 SHIFT: on each falling edge, shift in 9 bits (8 data bits, then parity); after the 9th bit, go to STOP.
REQ-018 STOP: on a falling edge, check stop bit == 1 and that the 9 data and parity bits contain an odd number of ones; then return to IDLE.
REQ-019 If the STOP check passes, SHALL write the byte to the FIFO in the same cycle.
REQ-020 If the STOP check fails, SHALL pulse frame_err for 1 cycle and write nothing.
REQ-021 In SHIFT or STOP, if TIMEOUT cycles pass with no falling edge, SHALL return to IDLE, discard partial bits and raise no flag.
REQ-022 data SHALL equal mem[rd_ptr] when ready=1, and 8'h00 when ready=0.
REQ-023 ready SHALL be 1 exactly when level > 0.
REQ-024 nextdata_n=0 while ready=1 SHALL advance rd_ptr by one per cycle; the next byte is visible on the following cycle.
REQ-025 nextdata_n=0 while ready=0 SHALL be ignored.
REQ-026 Pointers SHALL wrap modulo DEPTH.
REQ-027 level SHALL update in the cycle after the write or pop.
REQ-028 A simultaneous write and pop SHALL leave level unchanged, including when the FIFO is full; in that case the write is accepted with no overflow.
REQ-029 A write when level == DEPTH with no pop that cycle SHALL drop the byte and set overflow.
REQ-030 overflow SHALL clear on the next accepted pop.
REQ-031 The FIFO contents SHALL be unaffected by frame_err or a timeout.
REQ-032 Writes SHALL never carry a partially received byte.

Reset
REQ-033 clrn=0 SHALL asynchronously force: FSM to IDLE, bit count 0, pointers 0, level 0, ready 0, data 8'h00, overflow 0, frame_err 0, timeout counter 0, and all sync flops to 1.
REQ-034 Reset asserted mid-frame SHALL discard the frame; the first falling edge after release counts only as a start bit.
REQ-035 Outputs SHALL change only on clk edges after clrn deasserts.

Verification
REQ-036 Send frame for 0x1C (data 00111000 LSB first, parity 0, stop 1) -> ready=1, data=8'h1C, level=1, frame_err=0.
REQ-037 Send 0xF0 (parity 1), then 0x1C, then pop twice -> data 8'hF0, then 8'h1C, then ready=0, data=8'h00.
REQ-038 Send 0x1C with parity bit 1 -> frame_err high exactly 1 cycle, level stays 0.
REQ-039 Fill with DEPTH+1 frames and no pops -> level=DEPTH, overflow=1, head=first byte; one pop -> overflow=0, level=DEPTH-1.
REQ-040 Send 5 bits, then idle for TIMEOUT+10 cycles, then send full 0x1C -> exactly one entry, 8'h1C, no frame_err.
REQ-041 Assert clrn after the 6th bit with 2 bytes queued -> level=0, ready=0, overflow=0 immediately; the next full frame is received correctly.
